// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - load unit: request handshake, word reads, byte/half/word/dword extraction
// MEM_LOAD_SPLIT_EN enables misaligned loads as two-word reads; undefined raises an exception instead.
`timescale 1ns/1ps
module mem_load_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OFS_W  = $clog2(DATA_W/8)
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [2:0]        iLoadType,
  output logic              oMemRead,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemValid,
  output logic              oRespValid,
  output logic [DATA_W-1:0] oData,
  output logic              oException
);

  localparam int BYTES = DATA_W / 8;

`ifdef MEM_LOAD_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LWU = 3'd5;
  localparam logic [2:0] LT_LD  = 3'd6;

  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic [DATA_W-1:0] word0_q, word0_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              exc_q, exc_d;

  logic [OFS_W-1:0]  ofs;
  logic [ADDR_W-1:0] base_addr;
  logic              illegal_req;

  function automatic logic [3:0] load_size(input logic [2:0] t);
    case (t)
      LT_LW, LT_LWU: load_size = 4'd4;
      LT_LH, LT_LHU: load_size = 4'd2;
      LT_LD:         load_size = 4'd8;
      default:       load_size = 4'd1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [OFS_W-1:0] o);
    case (t)
      LT_LH, LT_LHU: misaligned = o[0];
      LT_LW, LT_LWU: misaligned = |o[1:0];
      LT_LD:         misaligned = |o;
      default:       misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic type_illegal(input logic [2:0] t);
    type_illegal = (t == 3'd7) || ((DATA_W == 32) && ((t == LT_LWU) || (t == LT_LD)));
  endfunction

  function automatic logic crosses(input logic [2:0] t, input logic [OFS_W-1:0] o);
    crosses = (5'(o) + 5'(load_size(t))) > 5'(BYTES);
  endfunction

  // The field always lands at bit 0 after shifting {hi,lo} right by the byte offset,
  // so aligned, in-word and split loads share one extraction path.
  function automatic logic [DATA_W-1:0] extract(input logic [2:0] t, input logic [OFS_W-1:0] o,
                                                input logic [DATA_W-1:0] hi,
                                                input logic [DATA_W-1:0] lo);
    logic [DATA_W-1:0] sh;
    sh = DATA_W'({hi, lo} >> {o, 3'b000});
    case (t)
      LT_LW:   extract = DATA_W'($signed(sh[31:0]));
      LT_LWU:  extract = DATA_W'(sh[31:0]);
      LT_LH:   extract = DATA_W'($signed(sh[15:0]));
      LT_LHU:  extract = DATA_W'(sh[15:0]);
      LT_LB:   extract = DATA_W'($signed(sh[7:0]));
      LT_LBU:  extract = DATA_W'(sh[7:0]);
      default: extract = sh;
    endcase
  endfunction

  assign ofs         = addr_q[OFS_W-1:0];
  assign base_addr   = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign illegal_req = type_illegal(iLoadType) ||
                       (!SPLIT && misaligned(iLoadType, iAddr[OFS_W-1:0]));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      word0_q <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      word0_q <= word0_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    word0_d = word0_q;
    data_d  = data_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (iReqValid) begin
          addr_d = iAddr;
          type_d = iLoadType;
          if (illegal_req) begin
            data_d  = '0;
            exc_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = RD1;
          end
        end
      end
      RD1: begin
        if (iMemValid) begin
          word0_d = iMemData;
          if (SPLIT && crosses(type_q, ofs)) begin
            state_d = RD2;
          end else begin
            data_d  = extract(type_q, ofs, '0, iMemData);
            exc_d   = 1'b0;
            state_d = RESP;
          end
        end
      end
      RD2: begin
        if (iMemValid) begin
          data_d  = extract(type_q, ofs, iMemData, word0_q);
          exc_d   = 1'b0;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oMemAddr = '0;
    if (state_q == RD1) oMemAddr = base_addr;
    else if (state_q == RD2) oMemAddr = base_addr + ADDR_W'(BYTES);
  end

  assign oReqReady  = (state_q == IDLE) && iRST_n;
  assign oMemRead   = (state_q == RD1) || (state_q == RD2);
  assign oRespValid = (state_q == RESP);
  assign oData      = data_q;
  assign oException = exc_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - directed bench for mem_load_unit on 32- and 64-bit datapaths
// Split-load expectations are selected by MEM_LOAD_SPLIT_EN.
`timescale 1ns/1ps
module tb_mem_load_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        rv32 = 1'b0, rr32, mr32, mv32 = 1'b0, resp32, e32;
  logic [31:0] a32 = '0, ma32, md32 = '0, d32;
  logic [2:0]  t32 = '0;
  logic        rv64 = 1'b0, rr64, mr64, mv64 = 1'b0, resp64, e64;
  logic [31:0] a64 = '0, ma64;
  logic [63:0] md64 = '0, d64;
  logic [2:0]  t64 = '0;

  mem_load_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .iCLK(clk), .iRST_n(rst_n), .iReqValid(rv32), .oReqReady(rr32), .iAddr(a32),
    .iLoadType(t32), .oMemRead(mr32), .oMemAddr(ma32), .iMemData(md32), .iMemValid(mv32),
    .oRespValid(resp32), .oData(d32), .oException(e32));

  mem_load_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .iCLK(clk), .iRST_n(rst_n), .iReqValid(rv64), .oReqReady(rr64), .iAddr(a64),
    .iLoadType(t64), .oMemRead(mr64), .oMemAddr(ma64), .iMemData(md64), .iMemValid(mv64),
    .oRespValid(resp64), .oData(d64), .oException(e64));

  bit          sel64 = 1'b0;
  logic        mr_m, resp_m, e_m;
  logic [31:0] ma_m;
  logic [63:0] d_m;
  assign mr_m   = sel64 ? mr64 : mr32;
  assign resp_m = sel64 ? resp64 : resp32;
  assign e_m    = sel64 ? e64 : e32;
  assign ma_m   = sel64 ? ma64 : ma32;
  assign d_m    = sel64 ? d64 : {32'h0, d32};

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] d;
  logic        e;
  logic [31:0] ra0, ra1;
  int          nrd, rcyc, vcyc;

  // Cycle 0 is the accept cycle; the memory answers each read lat cycles after it starts.
  task automatic run_load(input bit w64, input logic [31:0] a, input logic [2:0] t,
                          input logic [63:0] w0, input logic [63:0] w1, input int lat);
    int cyc;
    bit done;
    sel64 = w64;
    d = '0; e = 1'b0; ra0 = '0; ra1 = '0; nrd = 0; rcyc = -1; vcyc = -1; done = 1'b0;
    @(negedge clk);
    if (w64) begin rv64 = 1'b1; a64 = a; t64 = t; end
    else begin rv32 = 1'b1; a32 = a; t32 = t; end
    @(negedge clk);
    rv32 = 1'b0; rv64 = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (resp_m) begin
        d = d_m; e = e_m; rcyc = cyc; done = 1'b1;
      end else if (mr_m) begin
        if (nrd == 0) ra0 = ma_m; else ra1 = ma_m;
        if (lat > 1) begin
          repeat (lat - 1) @(negedge clk);
          cyc += lat - 1;
        end
        if (w64) begin md64 = (nrd == 0) ? w0 : w1; mv64 = 1'b1; end
        else begin md32 = (nrd == 0) ? w0[31:0] : w1[31:0]; mv32 = 1'b1; end
        vcyc = cyc;
        @(negedge clk);
        cyc++; mv32 = 1'b0; mv64 = 1'b0; nrd++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_tests++; if (rr32 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", rr32); end
    n_tests++; if (mr32 !== 1'b0) begin n_fail++; $display("FAIL reset_memread got %b want 0", mr32); end
    n_tests++; if (ma32 !== 32'h0) begin n_fail++; $display("FAIL reset_memaddr got %h want 0", ma32); end
    n_tests++; if (resp32 !== 1'b0) begin n_fail++; $display("FAIL reset_resp got %b want 0", resp32); end
    n_tests++; if (d32 !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", d32); end
    n_tests++; if (e32 !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b want 0", e32); end
    #9 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (rr32 !== 1'b1) begin n_fail++; $display("FAIL idle_ready32 got %b want 1", rr32); end
    n_tests++; if (rr64 !== 1'b1) begin n_fail++; $display("FAIL idle_ready64 got %b want 1", rr64); end
  endtask

  task automatic test_extract32();
    run_load(1'b0, 32'h0000_1003, 3'd3, 64'h80FF_1234, 64'h0, 3);
    n_tests++; if (ra0 !== 32'h0000_1000) begin n_fail++; $display("FAIL lb_addr got %h want 00001000", ra0); end
    n_tests++; if (rcyc !== vcyc + 1) begin n_fail++; $display("FAIL lb_latency got %0d want %0d", rcyc, vcyc + 1); end
    n_tests++; if (vcyc !== 3) begin n_fail++; $display("FAIL lb_valid_cycle got %0d want 3", vcyc); end
    n_tests++; if (d !== 64'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data got %h want ffffff80", d); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL lb_exc got %b want 0", e); end
    run_load(1'b0, 32'h0000_1003, 3'd4, 64'h80FF_1234, 64'h0, 1);
    n_tests++; if (d !== 64'h0000_0080) begin n_fail++; $display("FAIL lbu_data got %h want 00000080", d); end
    run_load(1'b0, 32'h0000_2002, 3'd2, 64'h9ABC_5678, 64'h0, 2);
    n_tests++; if (d !== 64'h0000_9ABC) begin n_fail++; $display("FAIL lhu_data got %h want 00009abc", d); end
    n_tests++; if (ra0 !== 32'h0000_2000) begin n_fail++; $display("FAIL lhu_addr got %h want 00002000", ra0); end
    run_load(1'b0, 32'h0000_2002, 3'd1, 64'h9ABC_5678, 64'h0, 2);
    n_tests++; if (d !== 64'hFFFF_9ABC) begin n_fail++; $display("FAIL lh_data got %h want ffff9abc", d); end
    run_load(1'b0, 32'h0000_2000, 3'd1, 64'h9ABC_5678, 64'h0, 1);
    n_tests++; if (d !== 64'h0000_5678) begin n_fail++; $display("FAIL lh_low_data got %h want 00005678", d); end
    run_load(1'b0, 32'h0000_3000, 3'd0, 64'hCAFE_F00D, 64'h0, 4);
    n_tests++; if (d !== 64'hCAFE_F00D) begin n_fail++; $display("FAIL lw_data got %h want cafef00d", d); end
    n_tests++; if (nrd !== 1) begin n_fail++; $display("FAIL lw_reads got %0d want 1", nrd); end
  endtask

  task automatic test_illegal();
    run_load(1'b0, 32'h0000_3000, 3'd5, 64'h1234_5678, 64'h0, 1);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL lwu32_exc got %b want 1", e); end
    n_tests++; if (rcyc !== 1) begin n_fail++; $display("FAIL lwu32_cycle got %0d want 1", rcyc); end
    n_tests++; if (nrd !== 0) begin n_fail++; $display("FAIL lwu32_reads got %0d want 0", nrd); end
    run_load(1'b0, 32'h0000_3000, 3'd6, 64'h1234_5678, 64'h0, 1);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL ld32_exc got %b want 1", e); end
    run_load(1'b0, 32'h0000_3000, 3'd7, 64'h1234_5678, 64'h0, 1);
    n_tests++; if (e !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL rsvd_exc got %b/%h want 1/0", e, d); end
  endtask

  task automatic test_misaligned();
`ifdef MEM_LOAD_SPLIT_EN
    run_load(1'b0, 32'h0FFF_FFFE, 3'd0, 64'h1122_3344, 64'h5566_7788, 2);
    n_tests++; if (ra0 !== 32'h0FFF_FFFC) begin n_fail++; $display("FAIL split_addr0 got %h want 0ffffffc", ra0); end
    n_tests++; if (ra1 !== 32'h1000_0000) begin n_fail++; $display("FAIL split_addr1 got %h want 10000000", ra1); end
    n_tests++; if (d !== 64'h7788_1122 || e !== 1'b0) begin n_fail++; $display("FAIL split_data got %h/%b want 77881122/0", d, e); end
    n_tests++; if (rcyc !== vcyc + 1) begin n_fail++; $display("FAIL split_latency got %0d want %0d", rcyc, vcyc + 1); end
    run_load(1'b0, 32'hFFFF_FFFF, 3'd0, 64'h1122_3344, 64'h5566_7788, 1);
    n_tests++; if (ra1 !== 32'h0000_0000) begin n_fail++; $display("FAIL split_wrap got %h want 00000000", ra1); end
    n_tests++; if (d !== 64'h6677_8811) begin n_fail++; $display("FAIL split_wrap_data got %h want 66778811", d); end
    run_load(1'b0, 32'h0000_1001, 3'd1, 64'h80FF_1234, 64'h0, 1);
    n_tests++; if (nrd !== 1) begin n_fail++; $display("FAIL inword_reads got %0d want 1", nrd); end
    n_tests++; if (d !== 64'hFFFF_FF12) begin n_fail++; $display("FAIL inword_data got %h want ffffff12", d); end
    run_load(1'b1, 32'h0000_000C, 3'd6, 64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908, 1);
    n_tests++; if (ra1 !== 32'h0000_0010) begin n_fail++; $display("FAIL ld64_split_addr1 got %h want 00000010", ra1); end
    n_tests++; if (d !== 64'h0B0A_0908_0706_0504) begin n_fail++; $display("FAIL ld64_split_data got %h want 0b0a090807060504", d); end
`else
    run_load(1'b0, 32'h0000_3001, 3'd0, 64'h1234_5678, 64'h0, 1);
    n_tests++; if (nrd !== 0) begin n_fail++; $display("FAIL mis_lw_reads got %0d want 0", nrd); end
    n_tests++; if (rcyc !== 1) begin n_fail++; $display("FAIL mis_lw_cycle got %0d want 1", rcyc); end
    n_tests++; if (e !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL mis_lw_resp got %b/%h want 1/0", e, d); end
    run_load(1'b0, 32'h0000_1001, 3'd1, 64'h80FF_1234, 64'h0, 1);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_lh_exc got %b want 1", e); end
    run_load(1'b1, 32'h0000_000C, 3'd6, 64'h0, 64'h0, 1);
    n_tests++; if (e !== 1'b1 || nrd !== 0) begin n_fail++; $display("FAIL mis_ld64 got %b/%0d want 1/0", e, nrd); end
`endif
  endtask

  task automatic test_datapath64();
    run_load(1'b1, 32'h0000_0008, 3'd6, 64'h0123_4567_89AB_CDEF, 64'h0, 2);
    n_tests++; if (ra0 !== 32'h0000_0008) begin n_fail++; $display("FAIL ld64_addr got %h want 00000008", ra0); end
    n_tests++; if (d !== 64'h0123_4567_89AB_CDEF || e !== 1'b0) begin n_fail++; $display("FAIL ld64_data got %h/%b want 0123456789abcdef/0", d, e); end
    run_load(1'b1, 32'h0000_000C, 3'd0, 64'h89AB_CDEF_0123_4567, 64'h0, 1);
    n_tests++; if (d !== 64'hFFFF_FFFF_89AB_CDEF) begin n_fail++; $display("FAIL lw64_data got %h want ffffffff89abcdef", d); end
    run_load(1'b1, 32'h0000_000C, 3'd5, 64'h89AB_CDEF_0123_4567, 64'h0, 1);
    n_tests++; if (d !== 64'h0000_0000_89AB_CDEF) begin n_fail++; $display("FAIL lwu64_data got %h want 0000000089abcdef", d); end
    run_load(1'b1, 32'h0000_000F, 3'd3, 64'h89AB_CDEF_0123_4567, 64'h0, 1);
    n_tests++; if (d !== 64'hFFFF_FFFF_FFFF_FF89) begin n_fail++; $display("FAIL lb64_data got %h want ffffffffffffff89", d); end
    run_load(1'b1, 32'h0000_000A, 3'd2, 64'h89AB_CDEF_0123_4567, 64'h0, 1);
    n_tests++; if (d !== 64'h0000_0000_0000_0123) begin n_fail++; $display("FAIL lhu64_data got %h want 0000000000000123", d); end
  endtask

  task automatic test_back_to_back();
    bit bad;
    run_load(1'b0, 32'h0000_1002, 3'd4, 64'h80FF_1234, 64'h0, 1);
    n_tests++; if (rr32 !== 1'b0) begin n_fail++; $display("FAIL resp_ready got %b want 0", rr32); end
    @(negedge clk);
    n_tests++; if (rr32 !== 1'b1) begin n_fail++; $display("FAIL after_resp_ready got %b want 1", rr32); end
    n_tests++; if (resp32 !== 1'b0 || d32 !== 32'h0000_00FF) begin n_fail++; $display("FAIL resp_hold got %b/%h want 0/000000ff", resp32, d32); end
    md32 = 32'hFFFF_FFFF; mv32 = 1'b1;
    @(negedge clk);
    mv32 = 1'b0;
    bad = (resp32 !== 1'b0) || (mr32 !== 1'b0) || (rr32 !== 1'b1);
    n_tests++; if (bad) begin n_fail++; $display("FAIL idle_memvalid got resp=%b rd=%b rdy=%b want 0/0/1", resp32, mr32, rr32); end
    run_load(1'b0, 32'h0000_1001, 3'd3, 64'h80FF_1234, 64'h0, 1);
    n_tests++; if (d !== 64'h0000_0012) begin n_fail++; $display("FAIL b2b_data got %h want 00000012", d); end
  endtask

  task automatic test_mid_reset();
    bit saw;
    sel64 = 1'b0;
    @(negedge clk);
    rv32 = 1'b1; a32 = 32'h0000_0040; t32 = 3'd0;
    @(negedge clk);
    rv32 = 1'b0;
    n_tests++; if (mr32 !== 1'b1) begin n_fail++; $display("FAIL midrst_rd1 got %b want 1", mr32); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (mr32 !== 1'b0) begin n_fail++; $display("FAIL midrst_memread got %b want 0", mr32); end
    saw = 1'b0;
    repeat (2) begin @(negedge clk); if (resp32 !== 1'b0) saw = 1'b1; end
    #2 rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (resp32 !== 1'b0) saw = 1'b1; end
    n_tests++; if (saw) begin n_fail++; $display("FAIL midrst_noresp got 1 want 0"); end
    run_load(1'b0, 32'h0000_0044, 3'd0, 64'hDEAD_BEEF, 64'h0, 1);
    n_tests++; if (d !== 64'hDEAD_BEEF || e !== 1'b0) begin n_fail++; $display("FAIL midrst_next got %h/%b want deadbeef/0", d, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_extract32();
    test_illegal();
    test_misaligned();
    test_datapath64();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Sequential, parametrised load unit between the core's load path and a word-wide data memory port.
- Accepts one load request at a time (address + load type) over a valid/ready handshake.
- Issues one word read, or two with the split feature, over a read/valid memory handshake, then extracts the byte/half/word/dword with sign or zero extension.
- Returns a one-cycle response pulse with data and an alignment/type exception flag. Supports 32- and 64-bit datapaths and variable memory latency.

Parameters:
DATA_W, 32, datapath and memory word width; legal values 32 or 64
ADDR_W, 32, byte address width
OFS_W, $clog2(DATA_W/8), byte-offset width (derived; do not override)

Ports:
iCLK  in  1  clock, rising edge
iRST_n  in  1  asynchronous active-low reset
iReqValid  in  1  load request valid
oReqReady  out  1  unit idle, request accepted when iReqValid&&oReqReady
iAddr  in  ADDR_W  byte address of the load
iLoadType  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=LWU 6=LD 7=reserved
oMemRead  out  1  memory read strobe; held until iMemValid
oMemAddr  out  ADDR_W  word-aligned read address (low OFS_W bits 0)
iMemData  in  DATA_W  read data, qualified by iMemValid
iMemValid  in  1  one-cycle pulse, read data valid
oRespValid  out  1  one-cycle response pulse
oData  out  DATA_W  extended load result, valid with oRespValid
oException  out  1  misaligned or illegal type, valid with oRespValid

Behaviour:
- Reset (async, iRST_n=0): state IDLE; oReqReady=0 while in reset, 1 in IDLE afterwards; oMemRead=0; oMemAddr=0; oRespValid=0; oData=0; oException=0. All internal registers cleared.
- FSM states: IDLE, RD1, RD2, RESP.
- IDLE:
  - On accept, latch iAddr/iLoadType.
  - Illegal type → RESP. Illegal means 7; 5 or 6 when DATA_W=32; or misaligned with split disabled.
  - Otherwise → RD1.
- Misalignment rules (offset = addr[OFS_W-1:0]):
  - LH/LHU: offset[0]!=0.
  - LW/LWU: offset[1:0]!=0.
  - LD: offset!=0.
  - LB/LBU: never misaligned.
- RD1: oMemRead=1, oMemAddr={addr[ADDR_W-1:OFS_W],0}; both held stable until iMemValid.
  - On iMemValid: capture word0.
  - If split needed → RD2, else → RESP.
- RD2: oMemAddr = first address + DATA_W/8, wrapping modulo 2^ADDR_W at the top of the address space; oMemRead=1.
  - On iMemValid: capture word1 → RESP.
- RESP: oRespValid=1 for exactly one cycle; oData/oException driven and held until next RESP → IDLE.
  - oReqReady=0 in RD1/RD2/RESP.
  - The earliest next accept is the cycle after RESP.
- Extraction:
  - Byte = bits [8*offset +: 8]; half = [16*offset[OFS_W-1:1] +: 16]; word = [32*offset[OFS_W-1:2] +: 32].
  - Signed types sign-extend to DATA_W; LHU/LBU/LWU zero-extend.
  - LW on DATA_W=64 sign-extends; LD passes through.
- Exception response: oData=0, oException=1; no memory access issued.
- Latency, aligned: accept at cycle 0, oMemRead from cycle 1, iMemValid at cycle N gives oRespValid at N+1. Exception: oRespValid at cycle 1.
- iMemValid outside RD1/RD2 is ignored. iMemValid is sampled only while oMemRead=1.
- Reset asserted mid-access: FSM abandons to IDLE; oMemRead drops immediately; no response is generated.

Optional Feature:
- MEM_LOAD_SPLIT_EN defined:
  - Misaligned LH/LHU/LW/LWU/LD are legal.
  - Performed as two reads (RD1 then RD2); the result is extracted from {word1,word0} shifted right by 8*offset.
  - oException=0 for these loads.
  - Loads that do not cross a word boundary use only RD1. Example: LH at offset 1 on DATA_W=32 is misaligned but in-word, so no split.
- Undefined: misaligned loads raise oException; RD2 is unreachable and can be optimised out.

Test Plan:
- DATA_W=32, LB addr=0x1003, memory returns 0x80FF_1234 after 3 cycles → oMemAddr=0x1000, oRespValid 1 cycle after iMemValid, oData=0xFFFF_FF80, oException=0.
- LHU addr=0x2002, data 0x9ABC_5678 → oData=0x0000_9ABC. LH with same data → 0xFFFF_9ABC.
- Split undefined, LW addr=0x3001 → no oMemRead, oRespValid at cycle 1, oException=1, oData=0.
- Split defined, LW addr=0x0FFF_FFFE (DATA_W=32), word0=0x1122_3344, word1=0x5566_7788:
  - Reads at 0x0FFF_FFFC then 0x1000_0000.
  - oData=0x7788_1122.
- Split defined, LW addr=0xFFFF_FFFF → second read address wraps to 0x0000_0000.
- DATA_W=64: LD addr=0x8 → data passthrough. LWU on DATA_W=32 → oException=1. iRST_n pulsed low during RD1 → oMemRead=0 immediately, no oRespValid, next request accepted normally.
